// File: rtl/fp_conv_pkg.sv
// Shared IEEE-754 single-precision constants, flag bit positions and the
// operand class type used by the float-to-fixed conversion path.
package fp_conv_pkg;

  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_BIAS   = 127;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  // Denormals classify as ZERO because they are flushed.
  function automatic fp_class_e fp32_classify(input logic [FP32_EXP_W-1:0]  e,
                                              input logic [FP32_MANT_W-1:0] m);
    if (e == '0) return ZERO;
    if (e == '1) return (m == '0) ? INF : NAN;
    return NORM;
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Round, saturate and format an aligned magnitude into sign-magnitude or
// two's complement. ROUND_NEAREST_EN selects RNE; otherwise truncation.
module fx_round_sat #(
  parameter int INT_BITS  = 1,
  parameter int FRAC_BITS = 20,
  parameter int OUT_TWOS  = 0
) (
  input  logic                          i_sign,
  input  logic                          i_zero,
  input  logic                          i_sat,
  input  logic [INT_BITS+FRAC_BITS-1:0] i_mag,
  input  logic                          i_guard,
  input  logic                          i_sticky,
  output logic [INT_BITS+FRAC_BITS:0]   o_data,
  output logic                          o_carry
);

  localparam int M = INT_BITS + FRAC_BITS;
  localparam int W = M + 1;

  logic [M:0]   w_sum;
  logic         w_sat;
  logic [M-1:0] w_mag;

`ifdef ROUND_NEAREST_EN
  logic w_inc;
  assign w_inc = i_guard & (i_sticky | i_mag[0]);
  assign w_sum = {1'b0, i_mag} + {{M{1'b0}}, w_inc};
`else
  logic w_unused_rnd;
  assign w_unused_rnd = i_guard ^ i_sticky;
  assign w_sum        = {1'b0, i_mag};
`endif

  // A rounding carry out of the magnitude is an overflow in its own right.
  assign o_carry = w_sum[M] & ~i_sat & ~i_zero;
  assign w_sat   = i_sat | w_sum[M];
  assign w_mag   = w_sat ? {M{1'b1}} : w_sum[M-1:0];

  always_comb begin
    o_data = '0;
    if (i_zero || (!w_sat && w_mag == '0)) begin
      o_data = '0;
    end else if (OUT_TWOS == 0) begin
      o_data = {i_sign, w_mag};
    end else if (w_sat) begin
      o_data = i_sign ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
    end else begin
      o_data = i_sign ? (~{1'b0, w_mag} + W'(1)) : {1'b0, w_mag};
    end
  end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// Three-stage IEEE-754 single to fixed-point converter with valid/ready flow
// control. Build with ROUND_NEAREST_EN for round-to-nearest-even.
module float_to_fixed_pipe
  import fp_conv_pkg::*;
#(
  parameter int INT_BITS  = 1,
  parameter int FRAC_BITS = 20,
  parameter int OUT_TWOS  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INT_BITS+FRAC_BITS:0] out_data,
  output logic [3:0]                  out_flags
);

  localparam int M  = INT_BITS + FRAC_BITS;
  localparam int W  = M + 1;
  localparam int AW = M + 26;
  localparam logic signed [9:0] SH_OFF  = 10'(FRAC_BITS - FP32_MANT_W);
  localparam logic signed [9:0] INT_S   = 10'(INT_BITS);
  localparam logic signed [9:0] BIAS_S  = 10'(FP32_BIAS);
  localparam logic signed [9:0] FAR_LIM = -10'sd25;
  localparam logic signed [9:0] LSH_OFF = 10'sd26;

  logic w_adv;
  logic r_s1_valid, r_s2_valid, r_out_valid;

  assign w_adv     = out_ready | ~r_out_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;

  // ---------------- S1: unpack and classify
  logic                    w_sign, w_big, w_min_neg;
  logic [FP32_EXP_W-1:0]   w_exp;
  logic [FP32_MANT_W-1:0]  w_mant;
  logic signed [9:0]       w_exp_unb;
  fp_class_e               w_cls;

  assign w_sign    = in_data[31];
  assign w_exp     = in_data[30:23];
  assign w_mant    = in_data[22:0];
  assign w_exp_unb = $signed({2'b00, w_exp}) - BIAS_S;
  assign w_cls     = fp32_classify(w_exp, w_mant);
  assign w_big     = (w_cls == NORM) && (w_exp_unb >= INT_S);
  // -2^INT_BITS is exactly the negative saturation word in two's complement.
  assign w_min_neg = (OUT_TWOS != 0) && w_sign && (w_exp_unb == INT_S) && (w_mant == '0);

  logic                   r_s1_sign, r_s1_sat, r_s1_ovf, r_s1_unf;
  fp_class_e              r_s1_cls;
  logic [FP32_MANT_W-1:0] r_s1_mant;
  logic signed [9:0]      r_s1_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_cls   <= ZERO;
      r_s1_sat   <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_unf   <= 1'b0;
      r_s1_mant  <= '0;
      r_s1_shift <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign  <= w_sign;
        r_s1_cls   <= w_cls;
        r_s1_sat   <= (w_cls == INF) || w_big;
        r_s1_ovf   <= (w_cls == INF) || (w_big && !w_min_neg);
        r_s1_unf   <= (w_cls == ZERO) && (w_mant != '0);
        r_s1_mant  <= w_mant;
        r_s1_shift <= w_exp_unb + SH_OFF;
      end
    end
  end

  // ---------------- S2: align; low 26 bits of w_aligned sit below the LSB
  logic          w_far, w_norm_ok;
  logic [9:0]    w_lsh;
  logic [AW-1:0] w_aligned;
  logic [M-1:0]  w_s2_mag;
  logic          w_s2_guard, w_s2_sticky;
  logic [3:0]    w_s2_flags;

  assign w_far       = r_s1_shift < FAR_LIM;
  assign w_lsh       = 10'(r_s1_shift + LSH_OFF);
  assign w_aligned   = {{(AW-24){1'b0}}, 1'b1, r_s1_mant} << w_lsh;
  assign w_s2_mag    = w_far ? '0 : w_aligned[AW-1:26];
  assign w_s2_guard  = ~w_far & w_aligned[25];
  assign w_s2_sticky = w_far | (|w_aligned[24:0]);
  assign w_norm_ok   = (r_s1_cls == NORM) && !r_s1_sat;

  always_comb begin
    w_s2_flags                = '0;
    w_s2_flags[FLG_INVALID]   = (r_s1_cls == NAN);
    w_s2_flags[FLG_OVERFLOW]  = r_s1_ovf;
    w_s2_flags[FLG_UNDERFLOW] = r_s1_unf;
    w_s2_flags[FLG_INEXACT]   = w_norm_ok ? (w_s2_guard | w_s2_sticky) : r_s1_unf;
  end

  logic         r_s2_sign, r_s2_zero, r_s2_sat, r_s2_guard, r_s2_sticky;
  logic [M-1:0] r_s2_mag;
  logic [3:0]   r_s2_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_sat    <= 1'b0;
      r_s2_mag    <= '0;
      r_s2_guard  <= 1'b0;
      r_s2_sticky <= 1'b0;
      r_s2_flags  <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign   <= r_s1_sign;
        r_s2_zero   <= (r_s1_cls == ZERO) || (r_s1_cls == NAN);
        r_s2_sat    <= r_s1_sat;
        r_s2_mag    <= w_s2_mag;
        r_s2_guard  <= w_s2_guard;
        r_s2_sticky <= w_s2_sticky;
        r_s2_flags  <= w_s2_flags;
      end
    end
  end

  // ---------------- S3: round, saturate, format
  logic [W-1:0] w_fx_data;
  logic         w_fx_carry;
  logic [3:0]   w_out_flags;

  fx_round_sat #(
    .INT_BITS (INT_BITS),
    .FRAC_BITS(FRAC_BITS),
    .OUT_TWOS (OUT_TWOS)
  ) u_round_sat (
    .i_sign  (r_s2_sign),
    .i_zero  (r_s2_zero),
    .i_sat   (r_s2_sat),
    .i_mag   (r_s2_mag),
    .i_guard (r_s2_guard),
    .i_sticky(r_s2_sticky),
    .o_data  (w_fx_data),
    .o_carry (w_fx_carry)
  );

  always_comb begin
    w_out_flags               = r_s2_flags;
    w_out_flags[FLG_OVERFLOW] = r_s2_flags[FLG_OVERFLOW] | w_fx_carry;
  end

  logic [W-1:0] r_out_data;
  logic [3:0]   r_out_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_data  <= w_fx_data;
        r_out_flags <= w_out_flags;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_flags = r_out_flags;

endmodule

// File: doc/float_to_fixed_pipe.md
Name: float_to_fixed_pipe

Overview:
Parametrised, pipelined IEEE-754 single-precision to fixed-point converter with a valid/ready handshake and backpressure. Output format is configurable: integer and fraction widths, sign-magnitude or two's complement. Adds saturation, optional rounding and exception flags. Sits between float datapaths and fixed-point DSP/accumulator blocks.

Parameters:
INT_BITS, 1, integer bits of output (1..16)
FRAC_BITS, 20, fractional bits of output (1..31)
OUT_TWOS, 0, 0 = sign-magnitude {sign, magnitude}; 1 = two's complement
(derived) W = 1 + INT_BITS + FRAC_BITS; defaults give the legacy 22-bit format.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  converter accepts input this cycle
in_data  in  32  IEEE-754 single
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  W  fixed-point result
out_flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Reset clears all stage valids, out_valid=0, out_data=0, out_flags=0. Reset mid-operation discards all in-flight data; no stale result appears after release.
- Three stages, latency 3 cycles at out_ready=1, throughput 1/cycle.
  - S1: unpack and classify.
  - S2: align with a barrel shift of {1,mant} by (exp-127+FRAC_BITS-23), left or right. Bits shifted out form guard and sticky.
  - S3: round, saturate, format, flags.
- Transfer rule: a transfer happens when valid && ready. Global advance is adv = out_ready || !out_valid, and in_ready = adv. When adv=0 all stages hold and out_data/out_flags stay stable. Bubbles are not collapsed.
- Classification:
  - exp==0: result 0. Denormals are flushed; underflow=1 if mant!=0.
  - exp==255 with mant!=0 (NaN): result 0, invalid=1.
  - exp==255 with mant==0 (Inf): saturate, overflow=1.
  - exp-127 >= INT_BITS: saturate, overflow=1. Exception for OUT_TWOS=1: exactly -2^INT_BITS is representable and gives no overflow.
  - Right shift beyond 25 bits: magnitude 0, and sticky holds all mantissa bits.
- inexact=1 whenever nonzero bits are discarded by the shift or by the flush.
- Saturation:
  - Sign-magnitude: {sign, all ones}.
  - Two's complement: positive 0111..1, negative 1000..0.
  - A rounding carry out of the magnitude also saturates and sets overflow.
- Zero results (including -0.0 and all flush cases) are all-zero words; the sign bit is cleared.
- Two's-complement negation is applied after rounding/saturation of the magnitude.
- Flags are sticky per result only, never accumulated.

Optional Feature:
ROUND_NEAREST_EN
- Defined: round-to-nearest-even on the guard/sticky bits (tie goes to even LSB).
- Undefined: truncation toward zero (legacy behaviour); the rounding adder is removed.
- inexact reporting is identical in both builds.

Decomposition:
- Package fp_conv_pkg:
  - FP32_EXP_W=8, FP32_MANT_W=23, FP32_BIAS=127.
  - Flag index constants FLG_INVALID=3, FLG_OVERFLOW=2, FLG_UNDERFLOW=1, FLG_INEXACT=0.
  - Class encoding typedef: ZERO, NORM, INF, NAN.
- Sub-module fx_round_sat (S3 combinational core: round, saturate, format), reusable by a future fixed-to-fixed requantiser.

Test Plan:
1. Defaults, 0x3F000000 (0.5) -> out_data 0x080000, flags 0, 3 cycles after acceptance.
2. 0xBFC00000 (-1.5) -> 0x380000 (OUT_TWOS=0); 0x280000 (OUT_TWOS=1); flags 0.
3. 0x40000000 -> 0x1FFFFF, overflow. 0x7F800000 -> 0x1FFFFF, overflow. 0x7FC00000 -> 0x000000, invalid. 0x00000001 -> 0x000000, underflow+inexact. 0x80000000 -> 0x000000, flags 0.
4. 0x3F80000C -> truncate build 0x100001, RNE build 0x100002; both inexact. 0x3FFFFFFF -> truncate 0x1FFFFF inexact; RNE 0x1FFFFF overflow+inexact.
5. Stream 8 distinct inputs with out_ready low for 4 cycles mid-stream -> in_ready drops while the pipe is full, out_data held stable, all 8 results in order, none lost or duplicated.
6. rst asserted for 1 cycle with 3 words in flight -> next cycle out_valid=0, out_data=0. The first output after release corresponds to the first post-reset input.
